// File: rtl/spi_mcp4822_dac.sv
// spi_mcp4822_dac
//
// SPI master that writes one 12-bit sample per frame to an MCP4822 dual DAC
// and then pulses LDAC so that the analog output updates. It is fed by the
// MCP3202 ADC stage and runs on that stage's 125 MHz system clock.
//
// Ports
//   clk           system clock
//   rst           synchronous, active-high reset
//   i_DATA        12-bit sample, sampled only while i_DATA_VALID = 1
//   i_DATA_VALID  one-cycle strobe qualifying i_DATA
//   MOSI          serial data to the DAC SDI pin, MSB first
//   SCK           SPI clock, mode 0,0, idles low
//   CS            DAC chip select, active low
//   LDAC          DAC latch strobe, active low
//   BUSY          high from the cycle after a frame start through DONE
//   DONE          one-cycle pulse when a frame, including LDAC, completes
//   OVERRUN       one-cycle pulse when a pending sample is overwritten
//   state_dbg     current FSM state, for debug and checker binding
//
// Input handshake: there is no ready signal. A strobe on i_DATA_VALID is
// always accepted on the edge that samples it. In IDLE (outside the DONE
// cycle) it starts a frame at once. At any other time, including the DONE
// cycle, it goes into a single pending slot. A newer strobe overwrites an
// occupied slot and raises OVERRUN on the following cycle.

module spi_mcp4822_dac #(
    parameter int CHANNEL    = 0,
    parameter int GAIN_1X    = 1,
    parameter int SCK_HALF   = 70,
    parameter int LDAC_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] i_DATA,
    input  logic        i_DATA_VALID,
    output logic        MOSI,
    output logic        SCK,
    output logic        CS,
    output logic        LDAC,
    output logic        BUSY,
    output logic        DONE,
    output logic        OVERRUN,
    output logic [2:0]  state_dbg
);

    localparam int CNT_MAX = (SCK_HALF > LDAC_WIDTH) ? SCK_HALF : LDAC_WIDTH;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(SCK_HALF - 1);
    localparam logic [CW-1:0] LDAC_LAST = CW'(LDAC_WIDTH - 1);
    localparam logic          CH_BIT    = (CHANNEL != 0);
    localparam logic          GA_BIT    = (GAIN_1X != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_SHIFT,
        S_CS_HOLD,
        S_GAP,
        S_LDAC_PULSE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;        // cycles elapsed in the current phase
    logic [4:0]    bit_cnt;    // bit being shifted, 0..15
    logic [14:0]   shreg;      // bits still to send after the one on MOSI
    logic          pend;
    logic [11:0]   pend_data;

    // Command word: channel, don't-care, gain, SHDN = active, sample.
    function automatic logic [15:0] cmd_word(input logic [11:0] d);
        return {CH_BIT, 1'b0, GA_BIT, 1'b1, d};
    endfunction

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            pend      <= 1'b0;
            pend_data <= '0;
            MOSI      <= 1'b0;
            SCK       <= 1'b0;
            CS        <= 1'b1;
            LDAC      <= 1'b1;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            DONE    <= 1'b0;
            OVERRUN <= 1'b0;

            // Any strobe outside IDLE is a busy-time sample for the pending slot.
            if (state != S_IDLE && i_DATA_VALID) begin
                pend_data <= i_DATA;
                pend      <= 1'b1;
                OVERRUN   <= pend;
            end

            case (state)
                S_IDLE: begin
                    cnt     <= '0;
                    bit_cnt <= '0;
                    if (i_DATA_VALID && !DONE) begin
                        // A fresh sample wins; any pending sample is dropped.
                        {MOSI, shreg} <= cmd_word(i_DATA);
                        CS            <= 1'b0;
                        BUSY          <= 1'b1;
                        state         <= S_CS_SETUP;
                        OVERRUN       <= pend;
                        pend          <= 1'b0;
                    end else if (pend) begin
                        {MOSI, shreg} <= cmd_word(pend_data);
                        CS            <= 1'b0;
                        BUSY          <= 1'b1;
                        state         <= S_CS_SETUP;
                        // A strobe in the DONE cycle refills the slot just emptied.
                        pend          <= i_DATA_VALID;
                        if (i_DATA_VALID) begin
                            pend_data <= i_DATA;
                        end
                    end else begin
                        BUSY <= 1'b0;
                        // Strobe in the DONE cycle: buffer it, start next cycle.
                        if (i_DATA_VALID) begin
                            pend      <= 1'b1;
                            pend_data <= i_DATA;
                        end
                    end
                end

                S_CS_SETUP: begin
                    if (cnt == HALF_LAST) begin
                        cnt   <= '0;
                        state <= S_SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_SHIFT: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!SCK) begin
                            SCK <= 1'b1;
                        end else begin
                            SCK <= 1'b0;
                            if (bit_cnt == 5'd15) begin
                                state <= S_CS_HOLD;
                            end else begin
                                // MOSI advances on the same edge SCK falls.
                                bit_cnt <= bit_cnt + 5'd1;
                                MOSI    <= shreg[14];
                                shreg   <= {shreg[13:0], 1'b0};
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_CS_HOLD: begin
                    if (cnt == HALF_LAST) begin
                        cnt   <= '0;
                        CS    <= 1'b1;
                        MOSI  <= 1'b0;
                        state <= S_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_GAP: begin
                    // Keeps CS high long enough before LDAC falls.
                    if (cnt == HALF_LAST) begin
                        cnt   <= '0;
                        LDAC  <= 1'b0;
                        state <= S_LDAC_PULSE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_LDAC_PULSE: begin
                    if (cnt == LDAC_LAST) begin
                        cnt   <= '0;
                        LDAC  <= 1'b1;
                        DONE  <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mcp4822_dac.sv
// tb_spi_mcp4822_dac
//
// Drives two DAC writers side by side (channel A / 1x gain with defaults,
// channel B / 2x gain) from the same sample strobes. Bus monitors rebuild
// each SPI frame from the pins. An abstract model of the single-slot input
// buffer predicts the frames and the OVERRUN count.

module tb_spi_mcp4822_dac;

    localparam int H = 70;
    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] i_data = '0;
    logic        i_valid = 1'b0;

    logic a_mosi, a_sck, a_cs, a_ldac, a_busy, a_done, a_ovr;
    logic b_mosi, b_sck, b_cs, b_ldac, b_busy, b_done, b_ovr;
    logic [2:0] a_st, b_st;

    spi_mcp4822_dac dut_a (
        .clk(clk), .rst(rst), .i_DATA(i_data), .i_DATA_VALID(i_valid),
        .MOSI(a_mosi), .SCK(a_sck), .CS(a_cs), .LDAC(a_ldac),
        .BUSY(a_busy), .DONE(a_done), .OVERRUN(a_ovr), .state_dbg(a_st)
    );

    spi_mcp4822_dac #(.CHANNEL(1), .GAIN_1X(0)) dut_b (
        .clk(clk), .rst(rst), .i_DATA(i_data), .i_DATA_VALID(i_valid),
        .MOSI(b_mosi), .SCK(b_sck), .CS(b_cs), .LDAC(b_ldac),
        .BUSY(b_busy), .DONE(b_done), .OVERRUN(b_ovr), .state_dbg(b_st)
    );

    // ---------------- clock / reset ----------------
    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bus monitors ----------------
    typedef struct {
        logic [15:0] word;
        int          bits;
        int          cs_len;
        int          first_rise;
        int          ph_min;
        int          ph_max;
        int          cs_fall;
    } frame_t;

    frame_t      a_fr_q[$];
    int          a_ldac_gap_q[$];
    int          a_ldac_w_q[$];
    logic [15:0] b_word_q[$];

    frame_t a_cur;
    int     a_last_edge = -1;
    int     a_cs_rise   = 0;
    int     a_ldac_fall = 0;
    int     a_done_cnt  = 0;
    int     a_ovr_cnt   = 0;
    logic   a_p_sck = 1'b0, a_p_cs = 1'b1, a_p_ldac = 1'b1;

    function automatic frame_t close_frame(input frame_t f, input int now);
        frame_t r;
        r        = f;
        r.cs_len = now - f.cs_fall;
        return r;
    endfunction

    always @(negedge clk) begin
        if (a_p_cs && !a_cs) begin
            a_cur.word       <= '0;
            a_cur.bits       <= 0;
            a_cur.cs_fall    <= cyc;
            a_cur.first_rise <= -1;
            a_cur.ph_min     <= 1 << 30;
            a_cur.ph_max     <= 0;
            a_last_edge      <= -1;
        end else if (!a_cs && a_sck != a_p_sck) begin
            if (a_last_edge >= 0) begin
                if (cyc - a_last_edge < a_cur.ph_min) a_cur.ph_min <= cyc - a_last_edge;
                if (cyc - a_last_edge > a_cur.ph_max) a_cur.ph_max <= cyc - a_last_edge;
            end
            a_last_edge <= cyc;
            if (a_sck) begin
                a_cur.word <= {a_cur.word[14:0], a_mosi};
                a_cur.bits <= a_cur.bits + 1;
                if (a_cur.bits == 0) a_cur.first_rise <= cyc - a_cur.cs_fall;
            end
        end
        if (!a_p_cs && a_cs) begin
            a_fr_q.push_back(close_frame(a_cur, cyc));
            a_cs_rise <= cyc;
        end
        if (a_p_ldac && !a_ldac) begin
            a_ldac_gap_q.push_back(cyc - a_cs_rise);
            a_ldac_fall <= cyc;
        end
        if (!a_p_ldac && a_ldac) a_ldac_w_q.push_back(cyc - a_ldac_fall);
        if (a_done) a_done_cnt <= a_done_cnt + 1;
        if (a_ovr)  a_ovr_cnt  <= a_ovr_cnt + 1;
        a_p_sck  <= a_sck;
        a_p_cs   <= a_cs;
        a_p_ldac <= a_ldac;
    end

    logic [15:0] b_word = '0;
    logic        b_p_sck = 1'b0, b_p_cs = 1'b1;

    always @(negedge clk) begin
        if (b_p_cs && !b_cs) b_word <= '0;
        else if (!b_cs && b_sck && !b_p_sck) b_word <= {b_word[14:0], b_mosi};
        if (!b_p_cs && b_cs) b_word_q.push_back(b_word);
        b_p_sck <= b_sck;
        b_p_cs  <= b_cs;
    end

    // ---------------- reference model ----------------
    logic [15:0] exp_q[$];
    logic [15:0] b_exp_q[$];
    logic        m_pend = 1'b0;
    logic [11:0] m_pend_data = '0;
    int          m_ovr = 0;

    function automatic logic [15:0] word_of(input bit ch, input bit ga, input logic [11:0] d);
        return {ch, 1'b0, ga, 1'b1, d};
    endfunction

    task automatic model_start(input logic [11:0] d);
        exp_q.push_back(word_of(1'b0, 1'b1, d));
        b_exp_q.push_back(word_of(1'b1, 1'b0, d));
    endtask

    task automatic model_busy(input logic [11:0] d);
        if (m_pend) m_ovr++;
        m_pend      = 1'b1;
        m_pend_data = d;
    endtask

    task automatic model_frame_end();
        if (m_pend) begin
            model_start(m_pend_data);
            m_pend = 1'b0;
        end
    endtask

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic strobe_now(input logic [11:0] d);
        i_data  = d;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic strobe(input logic [11:0] d);
        @(negedge clk);
        strobe_now(d);
    endtask

    task automatic wait_bits(input string tag, input int n);
        int budget;
        budget = 3000;
        while (!(a_cs == 1'b0 && a_cur.bits >= n) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) chk({tag, "_bits_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_done_pin(input string tag, output int dcyc);
        int budget;
        budget = 3000;
        @(negedge clk);
        while (a_done !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
        dcyc = cyc;
    endtask

    task automatic check_frame_after(input string tag, input int dcyc, output int fall);
        frame_t      f;
        logic [15:0] e, be, bw;
        int          gap, wid;
        fall = 0;
        if (a_fr_q.size() != 1 || exp_q.size() == 0 || b_word_q.size() != 1 ||
            b_exp_q.size() == 0 || a_ldac_gap_q.size() != 1 || a_ldac_w_q.size() != 1) begin
            chk({tag, "_frame_queued"}, 32'(a_fr_q.size()), 32'd1);
            return;
        end
        f   = a_fr_q.pop_front();
        e   = exp_q.pop_front();
        bw  = b_word_q.pop_front();
        be  = b_exp_q.pop_front();
        gap = a_ldac_gap_q.pop_front();
        wid = a_ldac_w_q.pop_front();
        chk({tag, "_word"},       32'(f.word),  32'(e));
        chk({tag, "_b_word"},     32'(bw),      32'(be));
        chk({tag, "_sck_rises"},  f.bits,       32'd16);
        chk({tag, "_cs_low"},     f.cs_len,     34 * H);
        chk({tag, "_first_rise"}, f.first_rise, 2 * H);
        chk({tag, "_phase_min"},  f.ph_min,     H);
        chk({tag, "_phase_max"},  f.ph_max,     H);
        chk({tag, "_ldac_setup"}, gap,          H);
        chk({tag, "_ldac_width"}, wid,          W);
        chk({tag, "_frame_len"},  dcyc - f.cs_fall, 35 * H + W);
        fall = f.cs_fall;
    endtask

    task automatic frame_done(input string tag, output int dcyc, output int fall);
        wait_done_pin(tag, dcyc);
        @(negedge clk);
        check_frame_after(tag, dcyc, fall);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int          d1, d2, f1, f2, k, dc0;
        logic [11:0] d;

        // Reset values, observed while rst is held.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cs",      32'(a_cs),      32'd1);
        chk("rst_sck",     32'(a_sck),     32'd0);
        chk("rst_mosi",    32'(a_mosi),    32'd0);
        chk("rst_ldac",    32'(a_ldac),    32'd1);
        chk("rst_busy",    32'(a_busy),    32'd0);
        chk("rst_done",    32'(a_done),    32'd0);
        chk("rst_overrun", 32'(a_ovr),     32'd0);
        chk("rst_b_cs",    32'(b_cs),      32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(a_busy), 32'd0);

        // Single write: start latency, bit 15 on MOSI, full frame.
        model_start(12'hD73);
        strobe(12'hD73);
        chk("t1_cs_latency",   32'(a_cs),   32'd0);
        chk("t1_busy_latency", 32'(a_busy), 32'd1);
        chk("t1_mosi_bit15",   32'(a_mosi), 32'd0);
        chk("t1_b_mosi_bit15", 32'(b_mosi), 32'd1);
        chk("t1_sck_setup",    32'(a_sck),  32'd0);
        frame_done("t1", d1, f1);
        model_frame_end();
        chk("t1_busy_after", 32'(a_busy),  32'd0);
        chk("t1_done_pulse", 32'(a_done),  32'd0);
        chk("t1_done_count", a_done_cnt,   32'd1);

        // Pending sample strobed mid-SHIFT starts one cycle after DONE.
        model_start(12'hD73);
        strobe(12'hD73);
        wait_bits("t3", 5);
        chk("t3_busy_mid", 32'(a_busy), 32'd1);
        model_busy(12'h003);
        strobe(12'h003);
        frame_done("t3a", d1, f1);
        model_frame_end();
        wait_done_pin("t3b", d2);
        @(negedge clk);
        check_frame_after("t3b", d2, f2);
        model_frame_end();
        chk("t3_back_to_back", f2 - d1, 32'd1);
        chk("t3_overrun", a_ovr_cnt, m_ovr);

        // Overwrite: the newest pending sample wins, OVERRUN pulses once.
        model_start(12'h111);
        strobe(12'h111);
        wait_bits("t4a", 3);
        model_busy(12'h222);
        strobe(12'h222);
        wait_bits("t4b", 9);
        model_busy(12'h333);
        strobe(12'h333);
        frame_done("t4a", d1, f1);
        model_frame_end();
        frame_done("t4b", d2, f2);
        model_frame_end();
        chk("t4_overrun", a_ovr_cnt, m_ovr);
        chk("t4_overrun_model", m_ovr, 32'd1);

        // Random samples with 0..3 busy-time strobes each.
        for (int it = 0; it < 3; it++) begin
            d = 12'($urandom);
            model_start(d);
            strobe(d);
            k = $urandom_range(0, 3);
            for (int j = 0; j < k; j++) begin
                repeat ($urandom_range(50, 500)) @(negedge clk);
                d = 12'($urandom);
                model_busy(d);
                strobe(d);
            end
            frame_done("rnd_a", d1, f1);
            model_frame_end();
            if (exp_q.size() > 0) begin
                frame_done("rnd_b", d2, f2);
                model_frame_end();
            end
            chk("rnd_overrun", a_ovr_cnt, m_ovr);
        end

        // Strobe coincident with DONE is buffered and starts one cycle later.
        d = 12'($urandom);
        model_start(d);
        strobe(d);
        wait_done_pin("t6a", d1);
        d = 12'($urandom);
        model_busy(d);
        strobe_now(d);
        check_frame_after("t6a", d1, f1);
        model_frame_end();
        frame_done("t6b", d2, f2);
        model_frame_end();
        chk("t6_coincident_start", f2 - d1, 32'd2);
        chk("t6_overrun", a_ovr_cnt, m_ovr);

        // Reset at bit 7 of a frame: immediate return to idle, no DONE.
        strobe(12'h5A5);
        wait_bits("t7", 8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t7_cs",   32'(a_cs),   32'd1);
        chk("t7_sck",  32'(a_sck),  32'd0);
        chk("t7_mosi", 32'(a_mosi), 32'd0);
        chk("t7_ldac", 32'(a_ldac), 32'd1);
        chk("t7_busy", 32'(a_busy), 32'd0);
        chk("t7_b_cs", 32'(b_cs),   32'd1);
        dc0 = a_done_cnt;
        repeat (36 * H + W) @(negedge clk);
        chk("t7_no_done", a_done_cnt, dc0);
        chk("t7_no_ldac", 32'(a_ldac_gap_q.size()), 32'd0);
        a_fr_q.delete();
        b_word_q.delete();
        a_ldac_gap_q.delete();
        a_ldac_w_q.delete();
        d = 12'($urandom);
        model_start(d);
        strobe(d);
        frame_done("t7_after", d1, f1);
        model_frame_end();
        chk("final_overrun", a_ovr_cnt, m_ovr);
        chk("final_exp_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
